// File: rtl/mte_rx_verify.sv
// Receive-side MTE verifier: collects a 2N-bit ciphertext frame byte by byte, decrypts it,
// regenerates the MAC over the plaintext and releases plaintext only when the MACs agree.

module decryption #(
    parameter int N = 256
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   key,
    input  logic [2*N-1:0] in_data,
    output logic [2*N-1:0] out_data
);
    logic [2*N-1:0] out_data_d, out_data_q;

    always_comb out_data_d = in_data ^ {key, key};

    always_ff @(posedge clock) begin
        if (reset) out_data_q <= '0;
        else       out_data_q <= out_data_d;
    end

    assign out_data = out_data_q;
endmodule

module macgen #(
    parameter int N = 256
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] key,
    input  logic [N-1:0] data,
    output logic [N-1:0] mac
);
    logic [N-1:0] mac_d, mac_q;

    // Keyed tag: plaintext rotated left one byte, mixed with the inverted key
    always_comb mac_d = {data[N-9:0], data[N-1:N-8]} ^ ~key;

    always_ff @(posedge clock) begin
        if (reset) mac_q <= '0;
        else       mac_q <= mac_d;
    end

    assign mac = mac_q;
endmodule

module mte_rx_verify #(
    parameter int N       = 256,
    parameter int DEC_LAT = 1,
    parameter int MAC_LAT = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] key,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         auth_ok,
    output logic [15:0]  fail_count
);
    localparam int FRAME_W = 2 * N;
    localparam int NBYTES  = FRAME_W / 8;
    localparam int CNT_W   = $clog2(NBYTES);
    localparam int WAIT_W  = 8;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [WAIT_W-1:0] DEC_WAIT  = WAIT_W'(DEC_LAT - 1);
    localparam logic [WAIT_W-1:0] MAC_WAIT  = WAIT_W'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_DECRYPT,
        S_MACGEN,
        S_COMPARE,
        S_OUTPUT
    } state_e;

    state_e              state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [WAIT_W-1:0]   wait_d, wait_q;
    logic [FRAME_W-1:0]  frame_d, frame_q;
    logic [N-1:0]        key_d, key_q;
    logic [N-1:0]        out_data_d, out_data_q;
    logic                auth_ok_d, auth_ok_q;
    logic [15:0]         fail_count_d, fail_count_q;
    logic [FRAME_W-1:0]  de_out;
    logic [N-1:0]        dmac;

    decryption #(.N(N)) u_dec (
        .clock    (clock),
        .reset    (reset),
        .key      (key_q),
        .in_data  (frame_q),
        .out_data (de_out)
    );

    macgen #(.N(N)) u_mac (
        .clock (clock),
        .reset (reset),
        .key   (key_q),
        .data  (de_out[FRAME_W-1:N]),
        .mac   (dmac)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_COLLECT;
            cnt_q        <= '0;
            wait_q       <= '0;
            frame_q      <= '0;
            key_q        <= '0;
            out_data_q   <= '0;
            auth_ok_q    <= 1'b0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            frame_q      <= frame_d;
            key_q        <= key_d;
            out_data_q   <= out_data_d;
            auth_ok_q    <= auth_ok_d;
            fail_count_q <= fail_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_COLLECT: begin
                if (in_valid) begin
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        wait_d  = DEC_WAIT;
                        state_d = S_DECRYPT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DECRYPT: begin
                if (wait_q == '0) begin
                    wait_d  = MAC_WAIT;
                    state_d = S_MACGEN;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_MACGEN: begin
                if (wait_q == '0) state_d = S_COMPARE;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_COMPARE: state_d = S_OUTPUT;
            S_OUTPUT:  if (out_ready) state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        frame_d      = frame_q;
        key_d        = key_q;
        out_data_d   = out_data_q;
        auth_ok_d    = auth_ok_q;
        fail_count_d = fail_count_q;
        if (state_q == S_COLLECT && in_valid) begin
            frame_d[(NBYTES - 1 - int'(cnt_q)) * 8 +: 8] = in_data;
            if (cnt_q == '0) key_d = key;
        end
        // An X/Z anywhere in either MAC makes the condition unknown and falls to rejection
        if (state_q == S_COMPARE) begin
            if (dmac == de_out[N-1:0]) begin
                out_data_d = de_out[FRAME_W-1:N];
                auth_ok_d  = 1'b1;
            end else begin
                out_data_d = '0;
                auth_ok_d  = 1'b0;
                if (fail_count_q != '1) fail_count_d = fail_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == S_COLLECT);
        out_valid = (state_q == S_OUTPUT);
    end

    assign out_data   = out_data_q;
    assign auth_ok    = auth_ok_q;
    assign fail_count = fail_count_q;
endmodule

// File: doc/mte_rx_verify.md
# mte_rx_verify

Receive-side counterpart of the MTE MAC-then-encrypt transmit block. It accepts a 64-byte ciphertext frame over a byte-wide valid/ready stream and assembles it into {cipher_data, cipher_mac}. It decrypts both halves with the team's `decryption` core and regenerates the MAC over the recovered plaintext with `macgen`. It then compares the two MACs and releases either the plaintext (authenticated) or all-zeros (rejected) on a valid/ready output port. It sits between the link byte receiver and the plaintext consumer.

## Interface
- N, 256, data/MAC/key width; frame is 2*N bits = 2*N/8 bytes
- DEC_LAT, 1, cycles from `decryption` input change to stable output
- MAC_LAT, 1, cycles from `macgen` input change to stable output
- clock  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high; one clock domain, no async reset
- key  input  N  shared secret; sampled when the first byte of a frame is accepted
- in_data  input  8  ciphertext byte, MSB-first
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a byte this cycle (in_valid & in_ready)
- out_data  output  N  plaintext if authenticated, else 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result (out_valid & out_ready)
- auth_ok  output  1  qualifies out_data: 1 = MAC match, 0 = mismatch
- fail_count  output  16  saturating count of rejected frames

## Operation
- Byte k of a frame (k = 0..2N/8-1) is written to frame bits [2N-1-8k -: 8]. This places byte 0 at the top of cipher_data = frame[2N-1:N] and places cipher_mac at frame[N-1:0].
- key_q latches `key` on the cycle byte 0 is accepted. key changes after that point have no effect on the frame in flight.
- FSM states:
  - COLLECT: in_ready=1; byte counter increments on each accept. The frame register is complete after the last byte (count 2N/8-1), then go to DECRYPT. The counter resets to 0.
  - DECRYPT: in_ready=0. frame and key_q drive both `decryption` halves. Wait DEC_LAT cycles via a down-counter, then go to MACGEN.
  - MACGEN: in_ready=0. Decrypted data half OutDe[2N-1:N] drives `macgen`. Wait MAC_LAT cycles, then go to COMPARE.
  - COMPARE: one cycle. match = (DMAC == decrypted MAC half OutDe[N-1:0]) using 4-state equality. Any X/Z counts as a mismatch. Register the result:
    - out_data = match ? OutDe[2N-1:N] : 0
    - auth_ok = match
    - fail_count += !match, saturating at 16'hFFFF, no wrap
  - Then go to OUTPUT.
  - OUTPUT: out_valid=1. Hold out_data and auth_ok stable until out_ready. On handshake, out_valid falls next cycle and the FSM returns to COLLECT.
- Decrypted plaintext is never visible on out_data for a rejected frame.
- in_data is ignored whenever in_valid=0 or the FSM is not in COLLECT.
- No frame delimiter is used. Framing is purely by byte count from reset or the previous frame.

## Timing
- Reset values: in_ready=1 (COLLECT), out_valid=0, out_data=0, auth_ok=0, fail_count=0. Byte counter, wait counter, frame register and key_q are all 0.
- Reset asserted in any state discards a partial frame or pending result with no output. The first cycle after reset deasserts accepts byte 0.
- Latency: last-byte accept at cycle T gives out_valid=1 at cycle T+DEC_LAT+MAC_LAT+2 when out_ready is held high.
- Throughput: one frame per 2N/8 + DEC_LAT + MAC_LAT + 2 cycles minimum. in_ready is 0 from the cycle after the last byte until the cycle after the output handshake.
- A stalled out_ready holds OUTPUT indefinitely. Upstream is back-pressured, with no byte loss and no overwrite.
- in_valid gaps during COLLECT only stretch collection and do not corrupt byte positions.
- fail_count updates only in COMPARE and is never cleared except by reset.

## Test plan
- Frame from MTE encrypt path, key=256'h1, IN=256'h0123…EF, out_ready=1 → exactly one out_valid pulse at T+DEC_LAT+MAC_LAT+2, out_data=IN, auth_ok=1, fail_count=0.
- Same frame with bit 0 of byte 40 flipped (MAC region) → out_valid, out_data=0, auth_ok=0, fail_count=1. Repeat with byte 5 flipped (data region) → same response, fail_count=2.
- Valid frame, out_ready=0 for 20 cycles → out_valid, out_data and auth_ok stable for all 20 cycles; in_ready=0 throughout. Bytes offered during the stall are not consumed and become byte 0 of the next frame after the handshake.
- Bytes with random in_valid gaps (~50% duty) plus a key change after byte 0 → result is identical to the gap-free, fixed-key case.
- Reset asserted after byte 30, then a full valid frame → no out_valid from the partial frame; the next frame authenticates with auth_ok=1.
- fail_count forced near saturation via 65,536 corrupted frames (or a preload in a test build) → holds at 16'hFFFF and does not wrap to 0.
